// File: rtl/threewire_slave_if.sv
// rtl/threewire_slave_if.sv - register-port bundle between the three-wire responder and a register file
interface threewire_slave_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] out_reg_addr;
    logic [DATA_W-1:0] out_reg_wr_data;
    logic              out_reg_wr_en;
    logic              out_reg_rd_en;
    logic [DATA_W-1:0] in_reg_rd_data;

    // The link responder drives the register port
    modport master (
        output out_reg_addr,
        output out_reg_wr_data,
        output out_reg_wr_en,
        output out_reg_rd_en,
        input  in_reg_rd_data
    );

    // The register file answers it
    modport slave (
        input  out_reg_addr,
        input  out_reg_wr_data,
        input  out_reg_wr_en,
        input  out_reg_rd_en,
        output in_reg_rd_data
    );
endinterface

// File: rtl/threewire_slave.sv
// rtl/threewire_slave.sv - three-wire link responder; abort counter enabled by TW_SLAVE_ABORT_CNT_EN
module threewire_slave #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_tw_clock,
    input  logic              in_tw_cs,
    inout  wire               io_tw_data,
    threewire_slave_if.master reg_if,
    output logic              out_busy,
    output logic [7:0]        out_abort_cnt
);

    typedef enum logic [2:0] {
        WAIT_CS_HIGH,
        IDLE,
        CMD,
        ADDR,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        DONE
    } state_t;

    // Counter value held before the rise that closes the address / the frame
    localparam logic [4:0] LAST_ADDR = 5'(ADDR_W);
    localparam logic [4:0] LAST_BIT  = 5'(ADDR_W + DATA_W);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    logic clk_s, cs_s, dat_s;
    logic rise_w, fall_w;
    logic last_rise_w, abort_w;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              drv_en_q, drv_en_d;
    logic              busy_q, busy_d;

    // Synchronise the asynchronous link inputs and remember the last link clock level
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            clk_sync_q <= '0;
            cs_sync_q  <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], in_tw_clock};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], in_tw_cs};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], io_tw_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];
    assign rise_w = clk_s & ~clk_prev_q;
    assign fall_w = ~clk_s & clk_prev_q;

    // The final rise of a frame beats a simultaneous chip-select release
    assign last_rise_w = rise_w && (cnt_q == LAST_BIT) &&
                         ((state_q == RD_DATA) || (state_q == WR_DATA));
    assign abort_w     = cs_s && !last_rise_w &&
                         ((state_q == CMD) || (state_q == ADDR) || (state_q == RD_FETCH) ||
                          (state_q == RD_DATA) || (state_q == WR_DATA));

    // Frame decoder: next state, shift register, captured fields and pulses
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        drv_en_d  = drv_en_q;
        busy_d    = busy_q;

        if (abort_w) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            drv_en_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_CS_HIGH: begin
                    if (cs_s) state_d = IDLE;
                end
                IDLE: begin
                    if (!cs_s) begin
                        busy_d  = 1'b1;
                        cnt_d   = 5'd0;
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (rise_w) begin
                        rw_d    = dat_s;
                        cnt_d   = cnt_q + 5'd1;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    if (rise_w) begin
                        shift_d = {shift_q[DATA_W-2:0], dat_s};
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == LAST_ADDR) begin
                            addr_d = {shift_q[ADDR_W-2:0], dat_s};
                            if (rw_q) begin
                                rd_en_d = 1'b1;
                                state_d = RD_FETCH;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                RD_FETCH: begin
                    // rd_en is high during the first cycle here; data arrives in the second
                    if (!rd_en_q) begin
                        shift_d = reg_if.in_reg_rd_data;
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rise_w) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == LAST_BIT) begin
                            drv_en_d = 1'b0;
                            state_d  = DONE;
                        end
                    end else if (fall_w) begin
                        if (!drv_en_q) drv_en_d = 1'b1;
                        else           shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                WR_DATA: begin
                    if (rise_w) begin
                        shift_d = {shift_q[DATA_W-2:0], dat_s};
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == LAST_BIT) begin
                            wr_data_d = {shift_q[DATA_W-2:0], dat_s};
                            wr_en_d   = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    if (cs_s) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = WAIT_CS_HIGH;
            endcase
        end
    end

    // Decoder state register
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= WAIT_CS_HIGH;
            cnt_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            drv_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            drv_en_q  <= drv_en_d;
            busy_q    <= busy_d;
        end
    end

`ifdef TW_SLAVE_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;

    // Saturating count of frames cut short by chip select
    always_ff @(posedge in_clk) begin
        if (in_rst)                               abort_cnt_q <= 8'd0;
        else if (abort_w && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
    end

    assign out_abort_cnt = abort_cnt_q;
`else
    assign out_abort_cnt = 8'd0;
`endif

    // Release the line as soon as reset or chip-select release is seen, not a cycle later
    assign io_tw_data = (drv_en_q && !in_rst && !cs_s) ? shift_q[DATA_W-1] : 1'bz;

    assign reg_if.out_reg_addr    = addr_q;
    assign reg_if.out_reg_wr_data = wr_data_q;
    assign reg_if.out_reg_wr_en   = wr_en_q;
    assign reg_if.out_reg_rd_en   = rd_en_q;
    assign out_busy               = busy_q;

endmodule

// File: tb/tb_threewire_slave.sv
// tb/tb_threewire_slave.sv - directed bench for threewire_slave
module tb_threewire_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       tw_clk;
    logic       tw_cs;
    logic       m_oe;
    logic       m_bit;
    wire        tw_data;
    logic       busy;
    logic [7:0] abort_cnt;

    logic [15:0] rd_value;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;

    logic        gap_line, post_line, mid_line, mid_busy, end_busy;
    logic [8:0]  mid_addr;
    logic [15:0] mid_wrdata;

    int checks = 0;
    int errors = 0;

`ifdef TW_SLAVE_ABORT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    pulldown (tw_data);
    assign tw_data = m_oe ? m_bit : 1'bz;

    threewire_slave_if #(.ADDR_W(9), .DATA_W(16)) reg_if ();

    threewire_slave dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_tw_clock   (tw_clk),
        .in_tw_cs      (tw_cs),
        .io_tw_data    (tw_data),
        .reg_if        (reg_if),
        .out_busy      (busy),
        .out_abort_cnt (abort_cnt)
    );

    always #5 clk = ~clk;

    // Register file model: read data valid only in the cycle after rd_en
    always @(posedge clk) reg_if.in_reg_rd_data <= reg_if.out_reg_rd_en ? rd_value : 16'h0000;

    // Observe register-port pulses away from the active edge
    always @(negedge clk) begin
        if (reg_if.out_reg_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= reg_if.out_reg_addr;
            wr_data <= reg_if.out_reg_wr_data;
        end
        if (reg_if.out_reg_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic rw, input logic [8:0] a, input logic [15:0] d,
                             input int nclk, input int ph, input int abort_at,
                             input int rst_at, input int gap, output logic [15:0] rdata);
        logic [25:0] fr;
        fr    = {rw, a, d};
        rdata = '0;
        tw_cs = 1'b0;
        cyc(ph);
        for (int i = 0; i < nclk; i++) begin
            if (i == abort_at) break;
            if (!rw || i < 10) begin
                m_oe  = 1'b1;
                m_bit = fr[25];
            end else begin
                m_oe = 1'b0;
            end
            fr = fr << 1;
            cyc(ph);
            tw_clk = 1'b1;
            if (rw && i >= 10) rdata = {rdata[14:0], tw_data};
            if (rw && i == 9) begin
                cyc(4);
                m_oe = 1'b0;
                cyc(ph - 5);
                gap_line = tw_data;
                cyc(1);
            end else if (i == rst_at) begin
                cyc(2);
                rst = 1'b1;
                cyc(1);
                rst        = 1'b0;
                mid_line   = tw_data;
                mid_busy   = busy;
                mid_addr   = reg_if.out_reg_addr;
                mid_wrdata = reg_if.out_reg_wr_data;
                cyc(ph - 3);
            end else if (i == 25) begin
                cyc(ph - 1);
                post_line = tw_data;
                cyc(1);
            end else begin
                cyc(ph);
            end
            tw_clk = 1'b0;
        end
        cyc(ph);
        end_busy = busy;
        m_oe     = 1'b0;
        tw_cs    = 1'b1;
        cyc(gap);
    endtask

    task automatic test_reset;
        checks++; if (reg_if.out_reg_addr !== 9'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", reg_if.out_reg_addr); end
        checks++; if (reg_if.out_reg_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", reg_if.out_reg_wr_data); end
        checks++; if (reg_if.out_reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", reg_if.out_reg_wr_en); end
        checks++; if (reg_if.out_reg_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", reg_if.out_reg_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (abort_cnt !== 8'h00) begin errors++; $display("FAIL reset_abort_cnt: got %h expected 00", abort_cnt); end
        checks++; if (tw_data !== 1'b0) begin errors++; $display("FAIL reset_line_released: got %b expected 0 (pulled)", tw_data); end
    endtask

    task automatic test_write;
        int w0, r0;
        logic [15:0] rd;
        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(1'b0, 9'h155, 16'h00AA, 26, 16, -1, -1, 32, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL write_rd_pulses: got %0d expected 0", rd_cnt - r0); end
        checks++; if (wr_addr !== 9'h155) begin errors++; $display("FAIL write_addr: got %h expected 155", wr_addr); end
        checks++; if (wr_data !== 16'h00AA) begin errors++; $display("FAIL write_data: got %h expected 00aa", wr_data); end
        checks++; if (end_busy !== 1'b1) begin errors++; $display("FAIL write_busy_before_cs: got %b expected 1", end_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_cs: got %b expected 0", busy); end
    endtask

    task automatic test_read;
        int w0, r0;
        logic [15:0] rd;
        rd_value = 16'hBEEF;
        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(1'b1, 9'h0A3, 16'h0000, 26, 16, -1, -1, 32, rd);
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_rd_pulses: got %0d expected 1", rd_cnt - r0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL read_wr_pulses: got %0d expected 0", wr_cnt - w0); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h expected beef", rd); end
        checks++; if (gap_line !== 1'b0) begin errors++; $display("FAIL read_z_before_fall: got %b expected 0 (pulled)", gap_line); end
        checks++; if (post_line !== 1'b0) begin errors++; $display("FAIL read_z_after_rise26: got %b expected 0 (pulled)", post_line); end
        checks++; if (reg_if.out_reg_addr !== 9'h0A3) begin errors++; $display("FAIL read_addr: got %h expected 0a3", reg_if.out_reg_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_cs: got %b expected 0", busy); end
    endtask

    task automatic test_abort;
        int w0;
        logic [15:0] rd;
        w0 = wr_cnt;
        run_frame(1'b0, 9'h0F0, 16'h5555, 26, 8, 14, -1, 16, rd);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_no_wr: got %0d expected 0", wr_cnt - w0); end
        checks++; if (abort_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL abort_cnt_1: got %0d expected %0d", abort_cnt, CNT_EN ? 1 : 0); end
        checks++; if (reg_if.out_reg_addr !== 9'h0F0) begin errors++; $display("FAIL abort_addr_complete: got %h expected 0f0", reg_if.out_reg_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        run_frame(1'b0, 9'h1AA, 16'h5555, 26, 8, 5, -1, 16, rd);
        checks++; if (reg_if.out_reg_addr !== 9'h0F0) begin errors++; $display("FAIL abort_addr_kept: got %h expected 0f0", reg_if.out_reg_addr); end
        checks++; if (abort_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL abort_cnt_2: got %0d expected %0d", abort_cnt, CNT_EN ? 2 : 0); end
        w0 = wr_cnt;
        run_frame(1'b0, 9'h001, 16'h1234, 26, 8, -1, -1, 16, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL abort_next_wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (wr_addr !== 9'h001) begin errors++; $display("FAIL abort_next_addr: got %h expected 001", wr_addr); end
        checks++; if (wr_data !== 16'h1234) begin errors++; $display("FAIL abort_next_data: got %h expected 1234", wr_data); end
    endtask

    task automatic test_reset_mid_frame;
        int w0, r0;
        logic [15:0] rd;
        rd_value = 16'hFFFF;
        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(1'b1, 9'h0A3, 16'h0000, 26, 16, -1, 17, 32, rd);
        checks++; if (mid_line !== 1'b0) begin errors++; $display("FAIL rst_line_released: got %b expected 0 (pulled)", mid_line); end
        checks++; if (mid_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", mid_busy); end
        checks++; if (mid_addr !== 9'h000) begin errors++; $display("FAIL rst_addr: got %h expected 000", mid_addr); end
        checks++; if (mid_wrdata !== 16'h0000) begin errors++; $display("FAIL rst_wr_data: got %h expected 0000", mid_wrdata); end
        checks++; if (end_busy !== 1'b0) begin errors++; $display("FAIL rst_edges_ignored_busy: got %b expected 0", end_busy); end
        checks++; if (post_line !== 1'b0) begin errors++; $display("FAIL rst_line_stays_z: got %b expected 0 (pulled)", post_line); end
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL rst_rd_pulses: got %0d expected 1", rd_cnt - r0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rst_no_wr: got %0d expected 0", wr_cnt - w0); end
        checks++; if (abort_cnt !== 8'h00) begin errors++; $display("FAIL rst_abort_cleared: got %h expected 00", abort_cnt); end
        w0 = wr_cnt;
        run_frame(1'b0, 9'h05A, 16'hC3C3, 26, 8, -1, -1, 16, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL rst_next_wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (wr_addr !== 9'h05A) begin errors++; $display("FAIL rst_next_addr: got %h expected 05a", wr_addr); end
        checks++; if (wr_data !== 16'hC3C3) begin errors++; $display("FAIL rst_next_data: got %h expected c3c3", wr_data); end
    endtask

    task automatic test_back_to_back;
        int w0;
        logic [15:0] rd;
        w0 = wr_cnt;
        run_frame(1'b0, 9'h0C3, 16'hA5A5, 26, 4, -1, -1, 8, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL b2b_first_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (wr_addr !== 9'h0C3) begin errors++; $display("FAIL b2b_first_addr: got %h expected 0c3", wr_addr); end
        checks++; if (wr_data !== 16'hA5A5) begin errors++; $display("FAIL b2b_first_data: got %h expected a5a5", wr_data); end
        run_frame(1'b0, 9'h13C, 16'h5A5A, 26, 4, -1, -1, 8, rd);
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_total_pulses: got %0d expected 2", wr_cnt - w0); end
        checks++; if (wr_addr !== 9'h13C) begin errors++; $display("FAIL b2b_second_addr: got %h expected 13c", wr_addr); end
        checks++; if (wr_data !== 16'h5A5A) begin errors++; $display("FAIL b2b_second_data: got %h expected 5a5a", wr_data); end
    endtask

    task automatic test_overlong;
        int w0;
        logic [15:0] rd;
        w0 = wr_cnt;
        run_frame(1'b0, 9'h1FF, 16'hFFFF, 30, 8, -1, -1, 16, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL long_wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (wr_addr !== 9'h1FF) begin errors++; $display("FAIL long_addr: got %h expected 1ff", wr_addr); end
        checks++; if (wr_data !== 16'hFFFF) begin errors++; $display("FAIL long_data: got %h expected ffff", wr_data); end
        checks++; if (end_busy !== 1'b1) begin errors++; $display("FAIL long_busy_in_done: got %b expected 1", end_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy_after_cs: got %b expected 0", busy); end
    endtask

    initial begin
        rst      = 1'b1;
        tw_clk   = 1'b0;
        tw_cs    = 1'b1;
        m_oe     = 1'b0;
        m_bit    = 1'b0;
        rd_value = 16'h0000;
        cyc(5);
        rst = 1'b0;
        cyc(6);
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_reset_mid_frame;
        test_back_to_back;
        test_overlong;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
